// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: rebuilds WIDTH-bit words, LSB- or MSB-first per frame.
// data_valid rises one cycle after the last bit; while it is unacked, arriving bits are dropped and flagged in overrun.
module shift_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             dir_right,
    input  logic             serial_in,
    input  logic             serial_valid,
    input  logic             data_ack,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sr, sr_n;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt, cnt_n;
    logic             dir_q, dir_n;
    logic [WIDTH-1:0] data_out_n;
    logic             data_valid_n;
    logic             busy_n;
    logic             overrun_n;
    logic             accept_start;

    // A frame can begin from IDLE, or from FULL in the same cycle the pending word is acked.
    assign accept_start = start && ((state == IDLE) || ((state == FULL) && data_ack));

    always_comb begin
        shifted      = dir_q ? {serial_in, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], serial_in};
        state_n      = state;
        sr_n         = sr;
        cnt_n        = cnt;
        dir_n        = dir_q;
        data_out_n   = data_out;
        data_valid_n = data_valid;
        busy_n       = busy;
        overrun_n    = overrun;

        case (state)
            IDLE: begin
            end
            RECV: begin
                if (serial_valid) begin
                    sr_n = shifted;
                    if (cnt == LAST) begin
                        cnt_n        = '0;
                        data_out_n   = shifted;
                        data_valid_n = 1'b1;
                        state_n      = FULL;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            FULL: begin
                if (serial_valid) begin
                    overrun_n = 1'b1;
                end
                if (data_ack) begin
                    data_valid_n = 1'b0;
                    busy_n       = 1'b0;
                    state_n      = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Overrides the FULL-state results above, including a bit dropped this same cycle.
        if (accept_start) begin
            state_n      = RECV;
            sr_n         = '0;
            cnt_n        = '0;
            dir_n        = dir_right;
            overrun_n    = 1'b0;
            busy_n       = 1'b1;
            data_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            sr         <= '0;
            cnt        <= '0;
            dir_q      <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            sr         <= sr_n;
            cnt        <= cnt_n;
            dir_q      <= dir_n;
            data_out   <= data_out_n;
            data_valid <= data_valid_n;
            busy       <= busy_n;
            overrun    <= overrun_n;
        end
    end

endmodule

// File: tb/tb_shift_deserializer.sv
// Randomized and directed bench for shift_deserializer against a queue-based frame model.
module tb_shift_deserializer;

    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         dir_right = 1'b0;
    logic         serial_in = 1'b0;
    logic         serial_valid = 1'b0;
    logic         data_ack = 1'b0;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         busy;
    logic         overrun;

    int checks = 0;
    int errors = 0;

    shift_deserializer #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dir_right   (dir_right),
        .serial_in   (serial_in),
        .serial_valid(serial_valid),
        .data_ack    (data_ack),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame model: 0 = idle, 1 = collecting bits, 2 = word waiting for ack.
    int           m_mode = 0;
    bit           m_bits[$];
    bit           m_dir = 1'b0;
    logic [W-1:0] m_dout = '0;
    bit           m_ovr = 1'b0;

    function automatic logic [W-1:0] pack_word();
        logic [W-1:0] w = '0;
        for (int i = 0; i < W; i++) begin
            if (m_dir) w[i] = m_bits[i];
            else       w[W-1-i] = m_bits[i];
        end
        return w;
    endfunction

    task automatic begin_frame();
        m_mode = 1;
        m_bits.delete();
        m_dir = dir_right;
        m_ovr = 1'b0;
    endtask

    always @(posedge clock) begin
        if (reset) begin
            m_mode = 0;
            m_bits.delete();
            m_dir  = 1'b0;
            m_dout = '0;
            m_ovr  = 1'b0;
        end else begin
            case (m_mode)
                0: if (start) begin_frame();
                1: if (serial_valid) begin
                    m_bits.push_back(serial_in);
                    if (m_bits.size() == W) begin
                        m_dout = pack_word();
                        m_mode = 2;
                    end
                end
                default: begin
                    if (serial_valid) m_ovr = 1'b1;
                    if (data_ack) begin
                        if (start) begin_frame();
                        else       m_mode = 0;
                    end
                end
            endcase
        end
        #1;
        chk("data_out",   data_out,   m_dout);
        chk("data_valid", data_valid, m_mode == 2);
        chk("busy",       busy,       m_mode != 0);
        chk("overrun",    overrun,    m_ovr);
    end

    task automatic cyc(input bit rst, input bit st, input bit dr,
                       input bit sv, input bit si, input bit ack);
        reset        = rst;
        start        = st;
        dir_right    = dr;
        serial_valid = sv;
        serial_in    = si;
        data_ack     = ack;
        @(posedge clock);
        #1;
    endtask

    task automatic send_bits(input logic [W-1:0] bits_first_to_last, input bit dr_noise,
                             input int max_gap);
        for (int i = W - 1; i >= 0; i--) begin
            int gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
            for (int g = 0; g < gap; g++) begin
                cyc(0, 0, dr_noise ? g[0] : 1'b0, 0, 1'b1, 0);
                chk("gap_valid_low", data_valid, 1'b0);
            end
            cyc(0, 0, dr_noise ? i[0] : 1'b0, 1, bits_first_to_last[i], 0);
            if (i == 1) chk("valid_before_last", data_valid, 1'b0);
        end
    endtask

    initial begin
        logic [W-1:0] prev;

        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("rst_data_out", data_out, 4'h0);
        chk("rst_valid", data_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overrun", overrun, 1'b0);

        // 1: MSB-first 1,0,1,1
        cyc(0, 1, 0, 0, 0, 0);
        chk("t1_busy_after_start", busy, 1'b1);
        send_bits(4'b1011, 0, 0);
        chk("t1_word", data_out, 4'b1011);
        chk("t1_valid", data_valid, 1'b1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t1_idle_busy", busy, 1'b0);

        // 2: LSB-first 1,0,1,1 with dir_right toggling mid-frame
        cyc(0, 1, 1, 0, 0, 0);
        send_bits(4'b1011, 1, 0);
        chk("t2_word", data_out, 4'b1101);
        cyc(0, 0, 0, 0, 0, 1);

        // 3: MSB-first 0,1,1,0 with random gaps
        cyc(0, 1, 0, 0, 0, 0);
        prev = data_out;
        for (int i = W - 1; i >= 1; i--) begin
            repeat ($urandom_range(3, 0)) cyc(0, 0, 0, 0, 1, 0);
            cyc(0, 0, 0, 1, i[0] ^ i[1], 0);
            chk("t3_hold_prev", data_out, prev);
        end
        repeat ($urandom_range(3, 0)) cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("t3_word", data_out, 4'b0110);

        // 4: overrun while pending, then ack+start restarts directly
        cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 1, 0, 1, 0, 0);
        chk("t4_overrun", overrun, 1'b1);
        chk("t4_word_kept", data_out, 4'b0110);
        cyc(0, 1, 0, 0, 0, 1);
        chk("t4_valid_cleared", data_valid, 1'b0);
        chk("t4_overrun_cleared", overrun, 1'b0);
        chk("t4_busy_recv", busy, 1'b1);
        send_bits(4'b1110, 0, 0);
        chk("t4_word", data_out, 4'b1110);
        cyc(0, 0, 0, 0, 0, 1);

        // 5: reset after 2 bits, then clean frame 1,1,0,0
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 1, 0);
        chk("t5_rst_data_out", data_out, 4'h0);
        chk("t5_rst_busy", busy, 1'b0);
        cyc(0, 1, 0, 0, 0, 0);
        send_bits(4'b1100, 0, 0);
        chk("t5_word", data_out, 4'b1100);
        cyc(0, 0, 0, 0, 0, 1);

        // 6: bit in the start cycle is ignored
        cyc(0, 1, 0, 1, 1, 0);
        send_bits(4'b0001, 0, 0);
        chk("t6_word", data_out, 4'b0001);
        cyc(0, 0, 0, 0, 0, 1);

        // Random traffic; the compare process checks every cycle.
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(99, 0) < 2, $urandom_range(3, 0) == 0, $urandom_range(1, 0),
                $urandom_range(2, 0) != 0, $urandom_range(1, 0), $urandom_range(3, 0) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_deserializer.md
Name: shift_deserializer

Overview:
- Serial-to-parallel receiver that assembles WIDTH-bit words from a qualified serial bit stream.
- It is the receiving end of the team's shift/rotate register datapath: a parallel-load shift register serializes words, and this block rebuilds them.
- Bit order (LSB-first or MSB-first) is selected per frame.
- Completed words are presented with a valid/ack handshake, and bits lost while a word is unacknowledged are flagged.

Parameters:
- WIDTH, default 4, word width in bits; legal range WIDTH >= 2.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a new frame; sampled only when a frame can be accepted.
- dir_right  input  1  1 = bits arrive LSB-first (shift in at MSB, shift right); 0 = MSB-first (shift in at LSB, shift left). Latched when start is accepted.
- serial_in  input  1  serial data bit.
- serial_valid  input  1  serial_in is a real bit this cycle.
- data_ack  input  1  consumer accepts data_out.
- data_out  output  WIDTH  last completed word.
- data_valid  output  1  data_out holds an unacknowledged word.
- busy  output  1  a frame is in progress or a word is pending.
- overrun  output  1  sticky: a bit was dropped because a word was pending.

Behaviour:
- Single clock domain. Reset is synchronous and active-high on `reset`, and it overrides everything, including mid-frame.
- Reset values:
  - state = IDLE, shift register = 0, bit counter = 0, latched dir = 0
  - data_out = 0, data_valid = 0, busy = 0, overrun = 0
- State machine (registered outputs):
  - IDLE:
    - busy = 0, data_valid = 0.
    - start = 1 moves to RECV, clears the shift register and counter, latches dir_right, and clears overrun.
    - serial_valid in the start cycle is ignored. The first bit is sampled no earlier than the cycle after start.
  - RECV:
    - busy = 1.
    - Each cycle with serial_valid = 1 shifts one bit in and increments the counter.
    - MSB-first shift: sr <= {sr[WIDTH-2:0], serial_in}.
    - LSB-first shift: sr <= {serial_in, sr[WIDTH-1:1]}.
    - Cycles with serial_valid = 0 hold all state. Gaps of any length are legal.
    - start is ignored in RECV (no restart or abort).
    - When the counter equals WIDTH-1 and serial_valid = 1:
      - data_out is loaded with the fully assembled word (including this bit).
      - data_valid = 1 is registered and the block moves to FULL.
      - data_valid rises in the clock cycle immediately after the last bit is sampled.
  - FULL:
    - busy = 1, data_valid = 1, data_out is stable.
    - serial_valid = 1 sets overrun = 1; the bit is discarded and the shift register is unchanged.
    - start without data_ack is ignored.
    - data_ack = 1 with start = 0: next state IDLE, data_valid = 0.
    - data_ack = 1 with start = 1: next state RECV directly, data_valid = 0, and the frame begins as from IDLE (overrun cleared, dir latched).
- data_out changes only when a word completes. It keeps its previous value throughout RECV and IDLE.
- overrun is sticky. It is cleared only by reset or by an accepted start.
- Bit counter:
  - width is $clog2(WIDTH); counts 0..WIDTH-1.
  - resets to 0 on completion, with no wrap past WIDTH-1.
- Latched dir is constant for the whole frame. Changing dir_right mid-frame has no effect.

Test Plan:
1. WIDTH=4, reset, then start with dir_right=0, then bits 1,0,1,1 with serial_valid on consecutive cycles -> data_out=4'b1011; data_valid=1 exactly one cycle after the 4th bit; busy=1 from the cycle after start.
2. start with dir_right=1, then bits 1,0,1,1 -> data_out=4'b1101; toggling dir_right mid-frame leaves the result unchanged.
3. MSB-first bits 0,1,1,0 with 0-3 idle cycles between bits -> data_out=4'b0110; data_out keeps its previous value and data_valid=0 until the 4th bit.
4. Word pending in FULL with no ack, then two serial_valid pulses -> overrun=1 and data_out unchanged. Then data_ack=1 with start=1 in the same cycle -> data_valid=0, overrun=0, state RECV; the next 4 bits form a correct word.
5. Reset asserted after 2 bits of a frame -> next cycle all outputs 0 and state IDLE; a following complete frame of 1,1,0,0 MSB-first -> data_out=4'b1100 (no leftover bits).
6. start and serial_valid=1 (serial_in=1) in the same IDLE cycle, then bits 0,0,0,1 MSB-first -> data_out=4'b0001, confirming the start-cycle bit is ignored.
